// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    localparam int WDOG_W = 16;

endpackage

// File: rtl/mem_arb2.sv
// rtl/mem_arb2.sv - round-robin arbiter sharing one variable-latency memory port between fetch and load/store
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_addr_i,
    input  logic                    i_read_i,
    output logic [DATA_WIDTH-1:0]   i_rdata_o,
    output logic                    i_ready_o,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
    input  logic                    d_write_i,
    input  logic                    d_read_i,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_ready_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    output logic                    mem_write_o,
    output logic                    mem_read_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    err_o
);

    localparam logic [WDOG_W-1:0] TIMEOUT_CNT = WDOG_W'(TIMEOUT);

    arb_state_t            state;
    arb_req_t              last_gnt;
    logic [WDOG_W-1:0]     wdog_cnt;
    logic [WDOG_W-1:0]     wdog_next;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  i_req;
    logic                  d_req;
    logic                  pick_d;

    assign i_req     = i_read_i;
    assign d_req     = d_read_i | d_write_i;
    // D wins when alone or when I took the previous grant
    assign pick_d    = d_req && (!i_req || last_gnt == REQ_I);
    assign wdog_next = wdog_cnt + 1'b1;

    assign i_ready_o = (state == ARB_GNT_I) && mem_ready_i;
    assign d_ready_o = (state == ARB_GNT_D) && mem_ready_i;
    assign i_rdata_o = i_ready_o ? mem_rdata_i : i_rdata_q;
    assign d_rdata_o = d_ready_o ? mem_rdata_i : d_rdata_q;

    always_comb begin
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_wstrb_o = d_wstrb_i;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        case (state)
            ARB_GNT_I: begin
                mem_addr_o  = i_addr_i;
                mem_wdata_o = '0;
                mem_wstrb_o = '0;
                mem_read_o  = i_read_i;
            end
            ARB_GNT_D: begin
                mem_write_o = d_write_i;
                mem_read_o  = d_read_i & ~d_write_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last_gnt  <= REQ_I;
            wdog_cnt  <= '0;
            err_o     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_d) begin
                        state    <= ARB_GNT_D;
                        last_gnt <= REQ_D;
                        wdog_cnt <= '0;
                    end else if (i_req) begin
                        state    <= ARB_GNT_I;
                        last_gnt <= REQ_I;
                        wdog_cnt <= '0;
                    end
                end
                ARB_GNT_I, ARB_GNT_D: begin
                    if (mem_ready_i) begin
                        state <= ARB_IDLE;
                        if (state == ARB_GNT_I) i_rdata_q <= mem_rdata_i;
                        else                    d_rdata_q <= mem_rdata_i;
                    end else begin
                        // saturate so a long hang cannot wrap past the threshold
                        if (wdog_cnt != '1) wdog_cnt <= wdog_next;
                        if (TIMEOUT != 0 && wdog_next == TIMEOUT_CNT) err_o <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb2.sv
// tb/tb_mem_arb2.sv - directed bench for mem_arb2 with a fixed-latency memory model
module tb_mem_arb2;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr_i, i_rdata_o, d_addr_i, d_wdata_i, d_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  d_wstrb_i, mem_wstrb_o;
    logic        i_read_i, i_ready_o, d_write_i, d_read_i, d_ready_o;
    logic        mem_write_o, mem_read_o, mem_ready_i, err_o;

    logic [31:0] mem [0:255];
    int          mcnt;
    logic        mem_stall;
    logic        mreq;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_addr_i(i_addr_i), .i_read_i(i_read_i), .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
        .d_write_i(d_write_i), .d_read_i(d_read_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .err_o(err_o)
    );

    // memory answers in the (LAT+1)th cycle of a held request
    assign mreq        = mem_read_o | mem_write_o;
    assign mem_ready_i = mreq && !mem_stall && (mcnt == LAT);
    assign mem_rdata_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
        end else if (mreq && !mem_ready_i) begin
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
        end
        if (!rst && mem_ready_i && mem_write_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb_o[b]) mem[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
    end

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drop_all();
        i_read_i  = 1'b0;
        d_read_i  = 1'b0;
        d_write_i = 1'b0;
    endtask

    // kind: 0 fetch, 1 store, 2 load; lat is -1 when no ready arrives
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output int lat,
                          output int foreign, output int wrote);
        bit got;
        got = 0; lat = 0; foreign = 0; wrote = 0; rdata = '0;
        if (kind == 0) begin
            i_addr_i = addr; i_read_i = 1'b1;
        end else begin
            d_addr_i = addr; d_wdata_i = wdata; d_wstrb_i = wstrb;
            d_write_i = (kind == 1); d_read_i = (kind == 2);
        end
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (kind == 0) begin
                if (d_ready_o) foreign++;
                if (mem_write_o) wrote++;
                if (i_ready_o) begin got = 1; rdata = i_rdata_o; end
            end else begin
                if (i_ready_o) foreign++;
                if (d_ready_o) begin got = 1; rdata = d_rdata_o; end
            end
        end
        @(posedge clk);
        #1 drop_all();
        if (!got) lat = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat, foreign, wrote, n;
        bit          got;
        logic [31:0] exp_addr [3];
        logic [31:0] exp_data [3];

        for (int k = 0; k < 256; k++) mem[k] = '0;
        mem[4] = 32'h00500093;
        mem[5] = 32'h00100113;
        mem[6] = 32'h00200193;

        vecs[0] = '{0, 32'h10, 32'h0,        4'h0, 1, 32'h00500093};
        vecs[1] = '{1, 32'h40, 32'hdeadbeef, 4'hf, 0, 32'h0};
        vecs[2] = '{2, 32'h40, 32'h0,        4'h0, 1, 32'hdeadbeef};
        vecs[3] = '{1, 32'h40, 32'h00001234, 4'h3, 0, 32'h0};
        vecs[4] = '{2, 32'h40, 32'h0,        4'h0, 1, 32'hdead1234};
        vecs[5] = '{0, 32'h14, 32'h0,        4'h0, 1, 32'h00100113};
        vecs[6] = '{1, 32'h44, 32'habcd5678, 4'hc, 0, 32'h0};
        vecs[7] = '{2, 32'h44, 32'h0,        4'h0, 1, 32'habcd0000};

        i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
        drop_all();
        mem_stall = 1'b0;
        do_reset();

        @(negedge clk);
        chk("rst_mem_read", {31'b0, mem_read_o}, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write_o}, 32'h0);
        chk("rst_readys", {30'b0, i_ready_o, d_ready_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_i_rdata", i_rdata_o, 32'h0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].kind, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, rd, lat, foreign, wrote);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(LAT + 2));
            chk($sformatf("vec%0d_foreign_ready", v), 32'(foreign), 32'h0);
            if (vecs[v].kind == 0) chk($sformatf("vec%0d_no_write", v), 32'(wrote), 32'h0);
            if (vecs[v].chk) chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
        end

        // simultaneous held requests from reset: D, I, D, I with an IDLE cycle between
        do_reset();
        i_addr_i = 32'h10; d_addr_i = 32'h40; i_read_i = 1'b1; d_read_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 0; n = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                if (i_ready_o || d_ready_o) begin
                    got = 1;
                    chk($sformatf("tie%0d_single_ready", k), {30'b0, i_ready_o, d_ready_o},
                        (k % 2 == 0) ? 32'h1 : 32'h2);
                    chk($sformatf("tie%0d_rdata", k), d_ready_o ? d_rdata_o : i_rdata_o,
                        (k % 2 == 0) ? 32'hdead1234 : 32'h00500093);
                end
            end
            if (!got) chk($sformatf("tie%0d_ready_seen", k), 32'h0, 32'h1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tie%0d_idle_gap", k), {31'b0, mem_read_o}, 32'h0);
            if (k == 3) drop_all();
        end
        @(posedge clk);
        #1;

        // back-to-back fetches, address advanced only after each ready
        exp_addr[0] = 32'h10; exp_addr[1] = 32'h14; exp_addr[2] = 32'h18;
        exp_data[0] = 32'h00500093; exp_data[1] = 32'h00100113; exp_data[2] = 32'h00200193;
        i_addr_i = exp_addr[0]; i_read_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            got = 0; n = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                if (i_ready_o) begin
                    got = 1;
                    chk($sformatf("b2b%0d_rdata", k), i_rdata_o, exp_data[k]);
                    chk($sformatf("b2b%0d_mem_addr", k), mem_addr_o, exp_addr[k]);
                end
            end
            chk($sformatf("b2b%0d_period", k), 32'(got ? n : -1), 32'(LAT + 2));
            @(posedge clk);
            #1;
            if (k < 2) i_addr_i = exp_addr[k + 1];
            else       i_read_i = 1'b0;
        end

        // watchdog: memory never answers
        mem_stall = 1'b1;
        d_addr_i = 32'h40; d_read_i = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 5)  chk("wdog_err_low_early", {31'b0, err_o}, 32'h0);
            if (c == 13) chk("wdog_err_set", {31'b0, err_o}, 32'h1);
            if (c == 21) begin
                chk("wdog_err_sticky", {31'b0, err_o}, 32'h1);
                chk("wdog_still_waiting", {30'b0, mem_read_o, d_ready_o}, 32'h2);
            end
        end
        @(posedge clk);
        #1 drop_all();
        mem_stall = 1'b0;
        do_reset();
        @(negedge clk);
        chk("wdog_rst_clears_err", {31'b0, err_o}, 32'h0);
        chk("wdog_rst_idle", {31'b0, mem_read_o}, 32'h0);
        @(posedge clk);
        #1;
        do_txn(0, 32'h10, 32'h0, 4'h0, rd, lat, foreign, wrote);
        chk("post_wdog_latency", 32'(lat), 32'(LAT + 2));
        chk("post_wdog_err_low", {31'b0, err_o}, 32'h0);

        // reset in the middle of a data grant, with a tie pending across reset
        d_addr_i = 32'h44; d_read_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_in_grant", {31'b0, mem_read_o}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        i_addr_i = 32'h10; i_read_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {29'b0, mem_read_o, mem_write_o, d_ready_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (i_ready_o || d_ready_o) begin
                got = 1;
                chk("midrst_first_tie_d", {30'b0, i_ready_o, d_ready_o}, 32'h1);
                chk("midrst_rdata", d_rdata_o, 32'habcd0000);
            end
        end
        if (!got) chk("midrst_ready_seen", 32'h0, 32'h1);
        @(posedge clk);
        #1 drop_all();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
